// File: rtl/m_load_pkg.sv
// Shared types for the M-stage load unit: load-op and FSM encodings plus alignment helpers.
package m_load_pkg;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LB        = 3'd1,
        LBU       = 3'd2,
        LH        = 3'd3,
        LHU       = 3'd4,
        LW        = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= LB) && (op <= LW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] low);
        case (op)
            LH, LHU: return low[0];
            LW:      return low != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/m_load_unit_if.sv
// Pipeline request, data-bus read and result signals of the M-stage load unit.
interface m_load_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  memLoadOp;
    logic [31:0] inAddr;
    logic        bus_rd_req;
    logic [31:0] bus_addr;
    logic        bus_rd_ack;
    logic [31:0] bus_rd_data;
    logic        out_valid;
    logic [31:0] outLoadData;
    logic        exc_adel;
    logic        exc_bus;
    logic        stall;

    // Load unit side
    modport slave (
        input  req_valid, memLoadOp, inAddr, bus_rd_ack, bus_rd_data,
        output req_ready, bus_rd_req, bus_addr, out_valid, outLoadData,
               exc_adel, exc_bus, stall
    );

    // Pipeline / bus environment side
    modport master (
        output req_valid, memLoadOp, inAddr, bus_rd_ack, bus_rd_data,
        input  req_ready, bus_rd_req, bus_addr, out_valid, outLoadData,
               exc_adel, exc_bus, stall
    );

endinterface

// File: rtl/m_load_ext.sv
// Combinational byte/halfword extraction and sign/zero extension of a loaded word.
module m_load_ext
    import m_load_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  low_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[8*low_i +: 8];
        half_sel = word_i[16*low_i[1] +: 16];
        data_o   = '0;
        case (op_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data_o = {24'h0, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LHU:     data_o = {16'h0, half_sel};
            LW:      data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/m_load_unit.sv
// M-stage load unit: alignment check, word read on the data bus, extract/extend, one-cycle result.
// Optional bus-ack watchdog enabled by defining LOAD_TIMEOUT_EN.
module m_load_unit
    import m_load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    m_load_unit_if.slave m
);

    state_e      state_q,    state_d;
    logic [2:0]  op_q,       op_d;
    logic [1:0]  low_q,      low_d;
    logic        bus_req_q,  bus_req_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] data_q,     data_d;
    logic        adel_q,     adel_d;
    logic [31:0] ext_data;
`ifdef LOAD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ebus_q, ebus_d;
`endif

    // Extraction works on the captured op/lowBit, not the live request inputs.
    m_load_ext u_ext (
        .op_i   (op_q),
        .low_i  (low_q),
        .word_i (m.bus_rd_data),
        .data_o (ext_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            low_q      <= '0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            data_q     <= '0;
            adel_q     <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            cnt_q      <= '0;
            ebus_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            low_q      <= low_d;
            bus_req_q  <= bus_req_d;
            bus_addr_q <= bus_addr_d;
            data_q     <= data_d;
            adel_q     <= adel_d;
`ifdef LOAD_TIMEOUT_EN
            cnt_q      <= cnt_d;
            ebus_q     <= ebus_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        low_d      = low_q;
        bus_req_d  = bus_req_q;
        bus_addr_d = bus_addr_q;
        data_d     = data_q;
        adel_d     = adel_q;
`ifdef LOAD_TIMEOUT_EN
        cnt_d      = cnt_q;
        ebus_d     = ebus_q;
`endif
        case (state_q)
            IDLE: begin
                if (m.req_valid && is_load_op(m.memLoadOp)) begin
                    op_d   = m.memLoadOp;
                    low_d  = m.inAddr[1:0];
                    adel_d = 1'b0;
`ifdef LOAD_TIMEOUT_EN
                    ebus_d = 1'b0;
                    cnt_d  = '0;
`endif
                    if (is_misaligned(m.memLoadOp, m.inAddr[1:0])) begin
                        adel_d  = 1'b1;
                        data_d  = '0;
                        state_d = DONE;
                    end else begin
                        bus_req_d  = 1'b1;
                        bus_addr_d = {m.inAddr[31:2], 2'b00};
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m.bus_rd_ack) begin
                    data_d    = ext_data;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
`ifdef LOAD_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This cycle would bring the count to the limit; an ack here would have won.
                    data_d    = '0;
                    ebus_d    = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m.req_ready   = (state_q == IDLE);
    assign m.stall       = (state_q != IDLE) || (m.req_valid && is_load_op(m.memLoadOp));
    assign m.bus_rd_req  = bus_req_q;
    assign m.bus_addr    = bus_addr_q;
    assign m.out_valid   = (state_q == DONE);
    assign m.outLoadData = data_q;
    assign m.exc_adel    = (state_q == DONE) && adel_q;
`ifdef LOAD_TIMEOUT_EN
    assign m.exc_bus     = (state_q == DONE) && ebus_q;
`else
    assign m.exc_bus     = 1'b0;
`endif

endmodule

// File: tb/tb_m_load_unit.sv
// Randomized self-checking bench for m_load_unit against a behavioural load model.
module tb_m_load_unit;

`ifdef LOAD_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 255;
    localparam bit          TO_EN = 1'b0;
`endif

    localparam logic [2:0] OP_NONE = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2,
                           OP_LH = 3'd3, OP_LHU = 3'd4, OP_LW = 3'd5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] last_data = '0;

    m_load_unit_if lif ();

    m_load_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .m     (lif)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Returns {misaligned, result} from the architectural load rules.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] word);
        logic [31:0] v;
        int unsigned off;
        off = addr % 4;
        case (op)
            OP_LB, OP_LBU: begin
                v = (word >> (8 * off)) & 32'hFF;
                if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
                return {1'b0, v};
            end
            OP_LH, OP_LHU: begin
                if (off % 2 != 0) return {1'b1, 32'h0};
                v = (word >> (8 * off)) & 32'hFFFF;
                if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
                return {1'b0, v};
            end
            OP_LW: begin
                if (off != 0) return {1'b1, 32'h0};
                return {1'b0, word};
            end
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    // One load; ack given in WAIT cycle delay+1. Called at a negedge, returns at a negedge.
    task automatic do_load(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] word, input int delay);
        logic [32:0] r;
        logic [31:0] exp_data;
        int w;
        bit done;
        r = model(op, addr, word);
        check_val("ready_idle", {31'b0, lif.req_ready}, 32'd1);
        lif.req_valid = 1'b1;
        lif.memLoadOp = op;
        lif.inAddr    = addr;
        #1;
        check_val("stall_req", {31'b0, lif.stall}, 32'd1);
        @(negedge clk);
        lif.req_valid = 1'b0;
        lif.memLoadOp = OP_NONE;
        lif.inAddr    = $urandom;
        if (r[32]) begin
            check_val("adel_no_bus", {31'b0, lif.bus_rd_req}, 32'd0);
            check_val("adel_valid", {31'b0, lif.out_valid}, 32'd1);
            check_val("adel_flag", {31'b0, lif.exc_adel}, 32'd1);
            check_val("adel_data", lif.outLoadData, 32'd0);
            exp_data = 32'd0;
        end else begin
            check_val("bus_addr", lif.bus_addr, {addr[31:2], 2'b00});
            exp_data = r[31:0];
            w = 1;
            done = 0;
            while (!done) begin
                check_val("bus_req_held", {31'b0, lif.bus_rd_req}, 32'd1);
                check_val("stall_wait", {31'b0, lif.stall}, 32'd1);
                lif.bus_rd_ack  = (w == delay + 1);
                lif.bus_rd_data = (w == delay + 1) ? word : $urandom;
                @(negedge clk);
                lif.bus_rd_ack = 1'b0;
                if (w == delay + 1) begin
                    done = 1;
                    check_val("ld_exc_bus", {31'b0, lif.exc_bus}, 32'd0);
                end else if (TO_EN && w == int'(TO)) begin
                    done = 1;
                    exp_data = 32'd0;
                    check_val("to_exc_bus", {31'b0, lif.exc_bus}, 32'd1);
                end else begin
                    check_val("no_early_valid", {31'b0, lif.out_valid}, 32'd0);
                    w++;
                end
            end
            check_val("ld_valid", {31'b0, lif.out_valid}, 32'd1);
            check_val("ld_adel", {31'b0, lif.exc_adel}, 32'd0);
            check_val("ld_req_drop", {31'b0, lif.bus_rd_req}, 32'd0);
            check_val("ld_data", lif.outLoadData, exp_data);
        end
        last_data = exp_data;
        @(negedge clk);
        check_val("valid_pulse", {31'b0, lif.out_valid}, 32'd0);
        check_val("exc_clear", {30'b0, lif.exc_adel, lif.exc_bus}, 32'd0);
        check_val("data_hold", lif.outLoadData, last_data);
    endtask

    initial begin
        lif.req_valid   = 1'b0;
        lif.memLoadOp   = OP_NONE;
        lif.inAddr      = '0;
        lif.bus_rd_ack  = 1'b0;
        lif.bus_rd_data = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_bus_req", {31'b0, lif.bus_rd_req}, 32'd0);
        check_val("rst_bus_addr", lif.bus_addr, 32'd0);
        check_val("rst_valid", {31'b0, lif.out_valid}, 32'd0);
        check_val("rst_data", lif.outLoadData, 32'd0);
        check_val("rst_exc", {30'b0, lif.exc_adel, lif.exc_bus}, 32'd0);
        check_val("rst_ready", {31'b0, lif.req_ready}, 32'd1);
        check_val("rst_stall", {31'b0, lif.stall}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        do_load(OP_LB, 32'h0000_1003, 32'h80FF_1234, 2);
        check_val("tp_lb", last_data, 32'hFFFF_FF80);
        do_load(OP_LHU, 32'h0000_2002, 32'h8001_ABCD, 0);
        check_val("tp_lhu", last_data, 32'h0000_8001);
        do_load(OP_LH, 32'h0000_2002, 32'h8001_ABCD, 0);
        check_val("tp_lh", last_data, 32'hFFFF_8001);
        do_load(OP_LW, 32'h0000_3001, 32'h1234_5678, 0);
        do_load(OP_LH, 32'h0000_3003, 32'h1234_5678, 0);

        // Reset in the middle of WAIT, then a stale ack after release.
        lif.req_valid = 1'b1;
        lif.memLoadOp = OP_LW;
        lif.inAddr    = 32'h0000_4000;
        @(negedge clk);
        lif.req_valid = 1'b0;
        lif.memLoadOp = OP_NONE;
        check_val("mid_bus_req", {31'b0, lif.bus_rd_req}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_val("mid_rst_req", {31'b0, lif.bus_rd_req}, 32'd0);
        lif.bus_rd_ack  = 1'b1;
        lif.bus_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        lif.bus_rd_ack = 1'b0;
        check_val("late_ack_valid", {31'b0, lif.out_valid}, 32'd0);
        check_val("late_ack_ready", {31'b0, lif.req_ready}, 32'd1);
        check_val("late_ack_req", {31'b0, lif.bus_rd_req}, 32'd0);
        check_val("late_ack_data", lif.outLoadData, 32'd0);
        last_data = 32'd0;
        @(negedge clk);

        // Non-load ops are ignored.
        for (int i = 0; i < 7; i++) begin
            lif.req_valid = 1'b1;
            lif.memLoadOp = (i < 5) ? OP_NONE : 3'(6 + i - 5);
            lif.inAddr    = $urandom;
            #1;
            check_val("nop_stall", {31'b0, lif.stall}, 32'd0);
            @(negedge clk);
            check_val("nop_bus", {30'b0, lif.bus_rd_req, lif.out_valid}, 32'd0);
            check_val("nop_ready", {31'b0, lif.req_ready}, 32'd1);
        end
        lif.req_valid = 1'b0;
        lif.memLoadOp = OP_NONE;

        // Ack while idle must not produce a result.
        lif.bus_rd_ack = 1'b1;
        @(negedge clk);
        lif.bus_rd_ack = 1'b0;
        check_val("idle_ack", {31'b0, lif.out_valid}, 32'd0);
        check_val("idle_ack_data", lif.outLoadData, last_data);

`ifdef LOAD_TIMEOUT_EN
        do_load(OP_LBU, 32'h0000_5001, 32'h0000_AB00, 50);
        check_val("tp_timeout", last_data, 32'd0);
        do_load(OP_LW, 32'h0000_6000, 32'hCAFE_F00D, int'(TO) - 1);
        check_val("tp_ack_at_limit", last_data, 32'hCAFE_F00D);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(1, 5));
            do_load(op, $urandom, $urandom, int'($urandom_range(0, 6)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
